// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// ---------------------------------------------------------------------------
// Time-multiplexing scan controller for a common-anode multi-digit 7-segment
// display that shares one BCD-to-7-segment decoder. A frame of hex nibbles is
// held in a display register and presented one digit per slot on bcd_out,
// together with the matching active-low digit enable on an_n. An optional dark
// gap separates slots to suppress ghosting. New frames arrive through a
// one-deep pending register and are only copied into the display register at
// a frame boundary (entry into the lit period of digit 0), so a frame is never
// shown torn.
//
// Optional build macro:
//   SEVEN_SEG_LEAD_ZERO_BLANK_EN - keep digit i>0 dark in its slot when
//   display nibbles i..NUM_DIGITS-1 are all zero. Slot timing, digit_idx and
//   frame_done are unaffected; digit 0 is never blanked.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = scan, 0 = display dark and idle
//   load_valid  in   load_data valid
//   load_ready  out  controller can accept a frame
//   load_data   in   4*NUM_DIGITS, nibble i in [4i+3:4i], digit 0 rightmost
//   bcd_out     out  4, nibble to the shared decoder
//   an_n        out  NUM_DIGITS, active-low digit enables (one-cold or all 1s)
//   digit_idx   out  index of the current slot
//   frame_done  out  one-cycle pulse in the last lit cycle of the last digit
//   state_dbg   out  current FSM state (IDLE=0, ON=1, GAP=2) for checkers
//
// Load handshake: a transfer happens on a rising clk edge where load_valid
// and load_ready are both 1. load_data is captured into the pending register
// and load_ready is 0 from the next cycle until the pending frame has been
// moved to the display at a frame boundary; load_data is ignored while
// load_ready is 0. The producer may hold load_valid as long as it likes.
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int GAP_TICKS       = 500
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [4*NUM_DIGITS-1:0]         load_data,
  output logic [3:0]                      bcd_out,
  output logic [NUM_DIGITS-1:0]           an_n,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done,
  output logic [1:0]                      state_dbg
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXT = (TICKS_PER_DIGIT > GAP_TICKS) ? TICKS_PER_DIGIT : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(TICKS_PER_DIGIT - 1);
  // GAP is never entered when GAP_TICKS is 0, so its terminal count is moot.
  localparam logic [CW-1:0] GAP_LAST = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pending;

  logic [1:0]              nxt_state;
  logic [CW-1:0]           nxt_cnt;
  logic [IW-1:0]           nxt_idx;
  logic [IW-1:0]           wrap_idx;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] nxt_display;
  logic                    blank;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   nxt_an;
  logic [3:0]              nxt_bcd;
  logic                    nxt_fd;

  assign state_dbg = state;
  assign wrap_idx  = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;

  // Next-state / slot sequencing. boundary marks the edge that enters the lit
  // period of digit 0, which is the only point a pending frame may land.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = digit_idx;
    boundary  = 1'b0;
    if (!enable) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          nxt_state = S_ON;
          nxt_cnt   = '0;
          nxt_idx   = '0;
          boundary  = 1'b1;
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            nxt_cnt = '0;
            if (GAP_TICKS > 0) begin
              nxt_state = S_GAP;
            end else begin
              nxt_idx  = wrap_idx;
              boundary = (digit_idx == IDX_LAST);
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            nxt_state = S_ON;
            nxt_cnt   = '0;
            nxt_idx   = wrap_idx;
            boundary  = (digit_idx == IDX_LAST);
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      endcase
    end
  end

  // A full pending register (load_ready low) is applied at the boundary; the
  // outputs below are derived from the post-boundary display so the first
  // lit cycle of a new frame already shows the new nibble.
  assign nxt_display = (boundary && !load_ready) ? pending : display;

`ifdef SEVEN_SEG_LEAD_ZERO_BLANK_EN
  // hi_zero[i] = nibbles i..NUM_DIGITS-1 of the next display are all zero.
  logic [NUM_DIGITS-1:0] hi_zero;
  always_comb begin : zero_scan
    logic acc;
    acc     = 1'b1;
    hi_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc        = acc & (nxt_display[4*i +: 4] == 4'd0);
      hi_zero[i] = acc;
    end
  end
  assign blank = (nxt_idx != '0) && hi_zero[nxt_idx];
`else
  assign blank = 1'b0;
`endif

  assign lit = (nxt_state == S_ON) && !blank;

  always_comb begin
    nxt_an = '1;
    if (lit) nxt_an[nxt_idx] = 1'b0;
  end

  // bcd_out follows the slot during ON and holds through GAP and IDLE, so the
  // nibble and the enable always change on the same edge.
  assign nxt_bcd = (nxt_state == S_ON) ? nxt_display[{nxt_idx, 2'b00} +: 4] : bcd_out;
  assign nxt_fd  = (nxt_state == S_ON) && (nxt_idx == IDX_LAST) && (nxt_cnt == ON_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      an_n       <= '1;
      bcd_out    <= 4'd0;
      frame_done <= 1'b0;
      display    <= '0;
      pending    <= '0;
      load_ready <= 1'b1;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      digit_idx  <= nxt_idx;
      an_n       <= nxt_an;
      bcd_out    <= nxt_bcd;
      frame_done <= nxt_fd;
      display    <= nxt_display;
      // Apply and accept are exclusive: apply needs load_ready low, accept
      // needs it high. A frame accepted on a boundary edge waits a frame.
      if (boundary && !load_ready) begin
        pending    <= '0;
        load_ready <= 1'b1;
      end else if (load_valid && load_ready) begin
        pending    <= load_data;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (GAP_TICKS=1 and GAP_TICKS=0)
// share stimulus; a time-position model per instance predicts every output.
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int T = 4;
  localparam int G = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;

  logic       ready_a, ready_b;
  logic [3:0] bcd_a, bcd_b;
  logic [3:0] an_a, an_b;
  logic [1:0] idx_a, idx_b;
  logic       fd_a, fd_b;
  logic [1:0] st_a, st_b;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .GAP_TICKS(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
    .load_ready(ready_a), .load_data(load_data), .bcd_out(bcd_a), .an_n(an_a),
    .digit_idx(idx_a), .frame_done(fd_a), .state_dbg(st_a)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .GAP_TICKS(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
    .load_ready(ready_b), .load_data(load_data), .bcd_out(bcd_b), .an_n(an_b),
    .digit_idx(idx_b), .frame_done(fd_b), .state_dbg(st_b)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by the time t since its last frame boundary:
  // slot = T+gap, digit = t/slot, lit while t%slot < T.
  bit          m_run [2];
  int          m_t   [2];
  logic [15:0] m_disp[2];
  logic [15:0] m_pend[2];
  bit          m_pfull[2];
  logic [3:0]  m_bcd [2];
  logic [3:0]  m_an  [2];
  int          m_idx [2];
  bit          m_fd  [2];

  function automatic bit blanked(input logic [15:0] d, input int i);
`ifdef SEVEN_SEG_LEAD_ZERO_BLANK_EN
    return (i > 0) && ((d >> (4 * i)) == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset(input int k);
    m_run[k] = 0; m_t[k] = 0; m_disp[k] = 0; m_pend[k] = 0; m_pfull[k] = 0;
    m_bcd[k] = 0; m_an[k] = 4'hF; m_idx[k] = 0; m_fd[k] = 0;
  endtask

  task automatic model_step(input int k);
    int  gap, slot, w;
    bit  xfer, bnd, lit;
    gap  = (k == 0) ? G : 0;
    slot = T + gap;
    xfer = load_valid && !m_pfull[k];
    bnd  = 0;
    if (!enable) begin
      m_run[k] = 0; m_t[k] = 0; m_an[k] = 4'hF; m_idx[k] = 0; m_fd[k] = 0;
    end else begin
      if (!m_run[k]) begin
        m_run[k] = 1; m_t[k] = 0; bnd = 1;
      end else begin
        m_t[k]++;
        if (m_t[k] == N * slot) begin m_t[k] = 0; bnd = 1; end
      end
      if (bnd && m_pfull[k]) begin m_disp[k] = m_pend[k]; m_pfull[k] = 0; end
      m_idx[k] = m_t[k] / slot;
      w        = m_t[k] % slot;
      lit      = (w < T);
      m_fd[k]  = lit && (m_idx[k] == N - 1) && (w == T - 1);
      if (lit) begin
        m_bcd[k] = 4'((m_disp[k] >> (4 * m_idx[k])) & 16'hF);
        m_an[k]  = blanked(m_disp[k], m_idx[k]) ? 4'hF : ~(4'b0001 << m_idx[k]);
      end else begin
        m_an[k] = 4'hF;
      end
    end
    if (xfer) begin m_pend[k] = load_data; m_pfull[k] = 1; end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("an_n",        16'(an_a),  16'(m_an[0]));
      chk("bcd_out",     16'(bcd_a), 16'(m_bcd[0]));
      chk("digit_idx",   16'(idx_a), 16'(m_idx[0]));
      chk("frame_done",  16'(fd_a),  16'(m_fd[0]));
      chk("load_ready",  16'(ready_a), 16'(!m_pfull[0]));
      chk("g0_an_n",       16'(an_b),  16'(m_an[1]));
      chk("g0_bcd_out",    16'(bcd_b), 16'(m_bcd[1]));
      chk("g0_digit_idx",  16'(idx_b), 16'(m_idx[1]));
      chk("g0_frame_done", 16'(fd_b),  16'(m_fd[1]));
      chk("g0_load_ready", 16'(ready_b), 16'(!m_pfull[1]));
    end
  end

  // ---------------- literal-rule trackers ----------------
  int   cyc = 0;
  logic en_q;
  always @(posedge clk) cyc++;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= enable;
  end

  int         last_fd_a = -1;
  int         last_fd_b = -1;
  int         run_b     = 0;
  logic [3:0] prev_an_b = 4'hF;

  always @(negedge clk) begin
    if (!rst_n || !en_q) begin
      last_fd_a = -1; last_fd_b = -1; run_b = 0; prev_an_b = 4'hF;
    end else begin
      if (fd_a) begin
        if (last_fd_a >= 0) chk("frame_period", 16'(cyc - last_fd_a), 16'd20);
        last_fd_a = cyc;
      end
      if (fd_b) begin
        if (last_fd_b >= 0) chk("g0_frame_period", 16'(cyc - last_fd_b), 16'd16);
        last_fd_b = cyc;
      end
`ifndef SEVEN_SEG_LEAD_ZERO_BLANK_EN
      chk("g0_never_dark", 16'(an_b == 4'hF), 16'd0);
`endif
      if (an_b != 4'hF) begin
        if (an_b == prev_an_b) run_b++;
        else begin
          if (prev_an_b != 4'hF) chk("g0_slot_len", 16'(run_b), 16'd4);
          run_b = 1;
        end
      end else begin
        run_b = 0;
      end
      prev_an_b = an_b;
    end
  end

  // ---------------- scoreboard: expected lit slots {an_n, bcd} ----------------
  logic [7:0] exp_q[$];
  bit         pin_started = 0;
  logic [3:0] prev_an_a   = 4'hF;

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0 && an_a != 4'hF && an_a != prev_an_a) begin
      if (!pin_started && an_a == 4'b1110) pin_started = 1;
      if (pin_started) chk("slot", 16'({an_a, bcd_a}), 16'(exp_q.pop_front()));
    end
    prev_an_a = an_a;
  end

  task automatic arm();
    exp_q.delete();
    pin_started = 0;
  endtask

  task automatic push_frame(input logic [15:0] f);
    for (int d = 0; d < N; d++) begin
      if (!blanked(f, d)) exp_q.push_back({~(4'b0001 << d), f[4*d +: 4]});
    end
  endtask

  task automatic wait_pins(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    timeout_fail("slot_sequence");
    exp_q.delete();
  endtask

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic send(input logic [15:0] d);
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 60; i++) begin
      if (ready_a) begin
        @(negedge clk);
        load_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    timeout_fail("load_accept");
  endtask

  task automatic wait_lit_idx(input int want);
    for (int i = 0; i < 60; i++) begin
      if (m_run[0] && m_idx[0] == want && (m_t[0] % (T + G)) < T) return;
      @(negedge clk);
    end
    timeout_fail("wait_digit");
  endtask

  task automatic wait_gap();
    for (int i = 0; i < 60; i++) begin
      if (m_run[0] && (m_t[0] % (T + G)) >= T) return;
      @(negedge clk);
    end
    timeout_fail("wait_gap");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an_n"},       16'(an_a),    16'hF);
    chk({tag, "_bcd_out"},    16'(bcd_a),   16'h0);
    chk({tag, "_digit_idx"},  16'(idx_a),   16'h0);
    chk({tag, "_frame_done"}, 16'(fd_a),    16'h0);
    chk({tag, "_load_ready"}, 16'(ready_a), 16'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 12AF shown F, A, 2, 1 from the first boundary.
    send(16'h12AF);
    arm();
    exp_q.push_back(8'hEF); exp_q.push_back(8'hDA);
    exp_q.push_back(8'hB2); exp_q.push_back(8'h71);
    enable = 1'b1;
    wait_pins(80);
    repeat (45) @(negedge clk);

    // 0003 during digit 2; 4444 stalls until after the boundary.
    wait_lit_idx(2);
    send(16'h0003);
    chk("stall_ready", 16'(ready_a), 16'h0);
    arm();
    push_frame(16'h0003);
    exp_q.push_back(8'hE4); exp_q.push_back(8'hD4);
    exp_q.push_back(8'hB4); exp_q.push_back(8'h74);
    send(16'h4444);
    wait_pins(120);

    // Drop enable in the lit period of digit 1.
    wait_lit_idx(1);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_an_n",       16'(an_a),  16'hF);
    chk("drop_digit_idx",  16'(idx_a), 16'h0);
    chk("drop_frame_done", 16'(fd_a),  16'h0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (an_a != 4'hF) break;
    end
    n = 0;
    while (an_a == 4'b1110 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("restart_slot_len", 16'(n), 16'd4);

    // Reset in a gap with a pending frame: it must be lost.
    send(16'h9876);
    wait_gap();
    chk("pending_before_reset", 16'(ready_a), 16'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arm();
    push_frame(16'h0000);
    push_frame(16'h0000);
    wait_pins(100);

    // Frame 0050: leading zeros.
    send(16'h0050);
    arm();
    for (int r = 0; r < 2; r++) begin
`ifdef SEVEN_SEG_LEAD_ZERO_BLANK_EN
      exp_q.push_back(8'hE0); exp_q.push_back(8'hD5);
`else
      exp_q.push_back(8'hE0); exp_q.push_back(8'hD5);
      exp_q.push_back(8'hB0); exp_q.push_back(8'h70);
`endif
    end
    wait_pins(100);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      load_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: load_data = 16'($urandom);
        1: load_data = 16'($urandom_range(0, 255));
        2: load_data = 16'($urandom_range(0, 15));
        default: load_data = 16'h0;
      endcase
      @(negedge clk);
    end
    load_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
